req_arb4_ctrl: RTL and testbench

- Four-requester arbiter/controller that shares one W-bit output path between four data sources, with a default value when no source is granted.
- Registered one-hot grant with two arbitration modes: fixed priority (req[0] highest) and round-robin.
- Per-grant hold limit guarantees fairness under contention.
- Sits in front of the shared z-style output mux and replaces ad-hoc sel priority chains with sequenced, registered selection.

---
 rtl/req_arb4_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_req_arb4_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/req_arb4_ctrl.sv
// req_arb4_ctrl: four-requester arbiter that shares one W-bit output path.
// Latency: a request is granted one cycle after it is sampled; dout is combinational from the grant registers.
// Backpressure: none. A requester holds req[i] high until it owns the path; contention is bounded by MAX_HOLD.
//
// Ports:
//   clk, rst          single rising-edge clock; synchronous active-high reset
//   req[3:0]          per-source request, held high while source i wants the path
//   mode              0 = fixed priority (index 0 highest), 1 = round-robin
//   din0..din3        source data, W bits each
//   dflt              value driven on dout while nobody owns the path
//   gnt[3:0]          registered one-hot grant (or zero)
//   gnt_id[1:0]       registered owner index, 0 when idle
//   gnt_valid         registered, equals |gnt
//   dout[W-1:0]       din[gnt_id] when gnt_valid, otherwise dflt
module req_arb4_ctrl #(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic         mode,
  input  logic [W-1:0] din0,
  input  logic [W-1:0] din1,
  input  logic [W-1:0] din2,
  input  logic [W-1:0] din3,
  input  logic [W-1:0] dflt,
  output logic [3:0]   gnt,
  output logic [1:0]   gnt_id,
  output logic         gnt_valid,
  output logic [W-1:0] dout
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Last hold count an owner may reach before it is forced to yield.
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state_q,     state_d;
  logic [3:0] gnt_q,       gnt_d;
  logic [1:0] gnt_id_q,    gnt_id_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic [3:0] hold_q,      hold_d;
  logic [1:0] ptr_q,       ptr_d;

  logic [3:0] others;
  logic       own_req;
  logic [2:0] pick_res;
  logic       pick_found;
  logic [1:0] pick_idx;

  // Arbitration: returns {found, index}. Candidates in excl_mask are skipped.
  // Fixed priority scans 0..3; round-robin scans ptr+1, ptr+2, ... so the
  // most recent owner is considered last.
  function automatic logic [2:0] pick(
    input logic [3:0] r,
    input logic [3:0] excl_mask,
    input logic       rr,
    input logic [1:0] ptr
  );
    logic [3:0] cand;
    logic       found;
    logic [1:0] idx;
    logic [1:0] c;
    cand  = r & ~excl_mask;
    found = 1'b0;
    idx   = 2'd0;
    for (int o = 0; o < 4; o++) begin
      c = rr ? (ptr + 2'(o + 1)) : 2'(o);
      if (!found && cand[c]) begin
        found = 1'b1;
        idx   = c;
      end
    end
    return {found, idx};
  endfunction

  // The current owner is always excluded from the pick. In IDLE gnt_q is
  // zero, so the same evaluation serves both the idle grant and hand-overs.
  assign others     = req & ~gnt_q;
  assign own_req    = |(req & gnt_q);
  assign pick_res   = pick(req, gnt_q, mode, ptr_q);
  assign pick_found = pick_res[2];
  assign pick_idx   = pick_res[1:0];

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    hold_d      = hold_q;
    ptr_d       = ptr_q;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = OWN;
          gnt_d       = 4'b0001 << pick_idx;
          gnt_id_d    = pick_idx;
          gnt_valid_d = 1'b1;
          hold_d      = 4'd0;
          ptr_d       = pick_idx;
        end
      end

      OWN: begin
        if (!own_req) begin
          // Release: hand over directly when someone else waits, so there
          // is no idle bubble between owners.
          if (pick_found) begin
            gnt_d       = 4'b0001 << pick_idx;
            gnt_id_d    = pick_idx;
            gnt_valid_d = 1'b1;
            hold_d      = 4'd0;
            ptr_d       = pick_idx;
          end else begin
            state_d     = IDLE;
            gnt_d       = 4'b0000;
            gnt_id_d    = 2'd0;
            gnt_valid_d = 1'b0;
            hold_d      = 4'd0;
          end
        end else if (|others) begin
          // Contended: the owner keeps the path for at most MAX_HOLD cycles.
          if (hold_q >= HOLD_LAST) begin
            gnt_d       = 4'b0001 << pick_idx;
            gnt_id_d    = pick_idx;
            gnt_valid_d = 1'b1;
            hold_d      = 4'd0;
            ptr_d       = pick_idx;
          end else begin
            hold_d = 4'(hold_q + 4'd1);
          end
        end else begin
          // Uncontested owner never times out.
          hold_d = 4'd0;
        end
      end

      default: begin
        state_d     = IDLE;
        gnt_d       = 4'b0000;
        gnt_id_d    = 2'd0;
        gnt_valid_d = 1'b0;
        hold_d      = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 4'b0000;
      gnt_id_q    <= 2'd0;
      gnt_valid_q <= 1'b0;
      hold_q      <= 4'd0;
      // Pointer at 3 makes index 0 the first round-robin candidate.
      ptr_q       <= 2'd3;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      hold_q      <= hold_d;
      ptr_q       <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;

  always_comb begin
    dout = dflt;
    if (gnt_valid_q) begin
      unique case (gnt_id_q)
        2'd0:    dout = din0;
        2'd1:    dout = din1;
        2'd2:    dout = din2;
        default: dout = din3;
      endcase
    end
  end

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_gnt_valid:   assert property (@(posedge clk) disable iff (rst) gnt_valid_q == (|gnt_q));
  a_gnt_id:      assert property (@(posedge clk) disable iff (rst) gnt_valid_q |-> gnt_q[gnt_id_q]);
  a_gnt_id_idle: assert property (@(posedge clk) disable iff (rst) !gnt_valid_q |-> (gnt_id_q == 2'd0));
  a_hold_bound:  assert property (@(posedge clk) disable iff (rst) hold_q <= HOLD_LAST);

endmodule

// File: tb/tb_req_arb4_ctrl.sv
module tb_req_arb4_ctrl;

  localparam int W = 8;
  localparam logic [W-1:0] D0 = 8'h11;
  localparam logic [W-1:0] D1 = 8'h22;
  localparam logic [W-1:0] D2 = 8'h33;
  localparam logic [W-1:0] D3 = 8'h44;
  localparam logic [W-1:0] DF = 8'hAA;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic         mode;
  logic [W-1:0] din0, din1, din2, din3, dflt;

  // u_dut: MAX_HOLD=4; u_dut1: MAX_HOLD=1 (switch-every-cycle boundary)
  logic [3:0]   gnt,       gnt1;
  logic [1:0]   gnt_id,    gnt_id1;
  logic         gnt_valid, gnt_valid1;
  logic [W-1:0] dout,      dout1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         due;
    logic [3:0] g;
    logic       chk1;
    logic [3:0] g1;
  } exp_t;

  exp_t sb[$];

  req_arb4_ctrl #(.W(W), .MAX_HOLD(4)) u_dut (
    .clk(clk), .rst(rst), .req(req), .mode(mode),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3), .dflt(dflt),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .dout(dout)
  );

  req_arb4_ctrl #(.W(W), .MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .mode(mode),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3), .dflt(dflt),
    .gnt(gnt1), .gnt_id(gnt_id1), .gnt_valid(gnt_valid1), .dout(dout1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] oh2idx(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    if (g[1]) r = 2'd1;
    if (g[2]) r = 2'd2;
    if (g[3]) r = 2'd3;
    return r;
  endfunction

  function automatic logic [W-1:0] exp_dout(input logic [3:0] g);
    logic [W-1:0] r;
    r = DF;
    if (g[0]) r = D0;
    if (g[1]) r = D1;
    if (g[2]) r = D2;
    if (g[3]) r = D3;
    return r;
  endfunction

  task automatic check_all(input string tag, input int c, input logic [3:0] exp_g,
                           input logic [3:0] a_g, input logic [1:0] a_id,
                           input logic a_v, input logic [W-1:0] a_d);
    checks++;
    if (a_g !== exp_g || a_id !== oh2idx(exp_g) || a_v !== (|exp_g) || a_d !== exp_dout(exp_g)) begin
      errors++;
      $display("FAIL %s cyc=%0d: got gnt=%b id=%0d vld=%b dout=%h, want gnt=%b id=%0d vld=%b dout=%h",
               tag, c, a_g, a_id, a_v, a_d, exp_g, oh2idx(exp_g), |exp_g, exp_dout(exp_g));
    end
  endtask

  // Monitor: compares any expectation whose observation cycle has arrived.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      if (sb[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_sample: due=%0d now=%0d", sb[0].due, cyc);
      end else begin
        check_all("dut_h4", cyc, sb[0].g, gnt, gnt_id, gnt_valid, dout);
        if (sb[0].chk1)
          check_all("dut_h1", cyc, sb[0].g1, gnt1, gnt_id1, gnt_valid1, dout1);
      end
      void'(sb.pop_front());
    end
  end

  // Drive one cycle of inputs and record the grant expected after this edge.
  task automatic step(input logic r, input logic m, input logic [3:0] rq,
                      input logic [3:0] eg, input logic c1, input logic [3:0] eg1);
    exp_t e;
    rst  = r;
    mode = m;
    req  = rq;
    e.due  = cyc + 1;
    e.g    = eg;
    e.chk1 = c1;
    e.g1   = eg1;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    mode = 1'b0;
    req  = 4'b0000;
    din0 = D0; din1 = D1; din2 = D2; din3 = D3; dflt = DF;
    @(posedge clk);
    #1;

    // Reset dominates full requests; idle afterwards drives dflt.
    step(1, 0, 4'b1111, 4'b0000, 1, 4'b0000);
    step(1, 0, 4'b1111, 4'b0000, 1, 4'b0000);
    step(0, 0, 4'b0000, 4'b0000, 1, 4'b0000);
    step(0, 0, 4'b0000, 4'b0000, 1, 4'b0000);

    // Fixed priority: owner 1, then direct hand-over to 3 on release.
    step(0, 0, 4'b1010, 4'b0010, 0, 4'b0000);
    step(0, 0, 4'b1010, 4'b0010, 0, 4'b0000);
    step(0, 0, 4'b1010, 4'b0010, 0, 4'b0000);
    step(0, 0, 4'b1000, 4'b1000, 0, 4'b0000);
    step(0, 0, 4'b1000, 4'b1000, 0, 4'b0000);
    step(0, 0, 4'b0000, 4'b0000, 0, 4'b0000);

    // Timeout with MAX_HOLD=4: four cycles each, alternating.
    for (int i = 0; i < 16; i++)
      step(0, 0, 4'b0011, ((i / 4) % 2 == 0) ? 4'b0001 : 4'b0010, 0, 4'b0000);
    step(0, 0, 4'b0000, 4'b0000, 0, 4'b0000);

    // Round-robin from reset: H1 rotates every cycle, H4 every four.
    step(1, 1, 4'b0000, 4'b0000, 1, 4'b0000);
    for (int i = 0; i < 17; i++)
      step(0, 1, 4'b1111, 4'b0001 << ((i / 4) % 4), 1, 4'b0001 << (i % 4));
    step(0, 1, 4'b0000, 4'b0000, 1, 4'b0000);

    // Uncontested owner keeps the grant indefinitely, even with MAX_HOLD=1.
    for (int i = 0; i < 20; i++)
      step(0, 0, 4'b0100, 4'b0100, 1, 4'b0100);
    step(0, 0, 4'b0000, 4'b0000, 1, 4'b0000);

    // Reset mid-grant; afterwards round-robin starts scanning at index 0.
    step(0, 0, 4'b0100, 4'b0100, 1, 4'b0100);
    step(0, 0, 4'b0110, 4'b0100, 1, 4'b0010);
    step(1, 0, 4'b0110, 4'b0000, 1, 4'b0000);
    step(0, 1, 4'b0110, 4'b0010, 1, 4'b0010);
    step(0, 1, 4'b0000, 4'b0000, 1, 4'b0000);

    // Mode change mid-grant does not disturb owner 3 (H4 contended, hold < 3).
    step(0, 1, 4'b1000, 4'b1000, 0, 4'b0000);
    step(0, 0, 4'b1001, 4'b1000, 0, 4'b0000);
    step(0, 0, 4'b0000, 4'b0000, 0, 4'b0000);

    repeat (2) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
